// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared types, sizes and pair-select helper for the RO PUF
package ro_puf_pkg;

    localparam int NUM_RO = 16;
    localparam int RESP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Returns {index_a, index_b}: adjacent pair when c=0, cross-half pair when c=1.
    function automatic logic [7:0] pair_sel(input int k, input logic c);
        logic [3:0] a;
        logic [3:0] b;
        if (c) begin
            a = 4'(k);
            b = 4'(k + RESP_W);
        end else begin
            a = 4'(2 * k);
            b = 4'(2 * k + 1);
        end
        return {a, b};
    endfunction

endpackage

// File: rtl/ro_model.sv
// rtl/ro_model.sv - one emulated ring oscillator: divider, toggle and saturating edge counter
module ro_model #(
    parameter int N     = 3,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    output logic [CNT_W-1:0] count
);

    localparam int DIV_W = $clog2(N + 1);

    logic [DIV_W-1:0] div;
    logic             ro;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            ro    <= 1'b0;
            count <= '0;
        end else if (clr) begin
            div   <= '0;
            ro    <= 1'b0;
            count <= '0;
        end else if (run) begin
            if (div == DIV_W'(N - 1)) begin
                div <= '0;
                ro  <= ~ro;
                // The wrap that drives ro from 0 to 1 is the rising edge being counted.
                if (!ro && count != {CNT_W{1'b1}}) begin
                    count <= count + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_oscillator_puf.sv
// rtl/ring_oscillator_puf.sv - 16-RO PUF: measurement FSM, pair compare and response register
module ring_oscillator_puf
    import ro_puf_pkg::*;
#(
    parameter int n0  = 3,
    parameter int n1  = 3,
    parameter int n2  = 2,
    parameter int n3  = 3,
    parameter int n4  = 8,
    parameter int n5  = 3,
    parameter int n6  = 3,
    parameter int n7  = 5,
    parameter int n8  = 8,
    parameter int n9  = 2,
    parameter int n10 = 4,
    parameter int n11 = 3,
    parameter int n12 = 6,
    parameter int n13 = 7,
    parameter int n14 = 5,
    parameter int n15 = 5,
    parameter int WINDOW     = 64,
    parameter int READY_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [RESP_W-1:0] chall_in,
    output logic [RESP_W-1:0] response,
    output logic              ready
);

    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int HOLD_W = $clog2(READY_HOLD + 1);
    localparam int N_ARR [NUM_RO] = '{n0, n1, n2, n3, n4, n5, n6, n7,
                                      n8, n9, n10, n11, n12, n13, n14, n15};

    state_t            state;
    logic [CNT_W-1:0]  win_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cnt [NUM_RO];
    logic [RESP_W-1:0] resp_next;
    logic [7:0]        sel;
    logic              clr;
    logic              run;

    assign clr = (state == IDLE) && en;
    // win_cnt reaching WINDOW marks the extra COUNT cycle used to sample settled counts.
    assign run = (state == COUNT) && (win_cnt < CNT_W'(WINDOW));

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
        ro_model #(
            .N     (N_ARR[i]),
            .CNT_W (CNT_W)
        ) u_ro (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .run   (run),
            .count (cnt[i])
        );
    end

    always_comb begin
        resp_next = '0;
        sel       = '0;
        for (int k = 0; k < RESP_W; k++) begin
            sel          = pair_sel(k, chall_in[k]);
            resp_next[k] = cnt[sel[7:4]] > cnt[sel[3:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            hold_cnt <= '0;
            response <= '0;
            ready    <= 1'b0;
        end else if (!en) begin
            state    <= IDLE;
            win_cnt  <= '0;
            hold_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= COUNT;
                    win_cnt <= '0;
                end
                COUNT: begin
                    if (win_cnt == CNT_W'(WINDOW)) begin
                        state    <= DONE;
                        response <= resp_next;
                        ready    <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (hold_cnt == HOLD_W'(READY_HOLD - 1)) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_oscillator_puf.sv
// tb/tb_ring_oscillator_puf.sv - directed self-checking bench for ring_oscillator_puf
module tb_ring_oscillator_puf;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] chall_in;
    logic [7:0] response;
    logic       ready;
    logic [7:0] response_t;
    logic       ready_t;

    int tests;
    int fails;
    logic saw_ready;

    ring_oscillator_puf dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .chall_in (chall_in),
        .response (response),
        .ready    (ready)
    );

    // Same as defaults except n2=3, giving RO2 and RO3 equal counts.
    ring_oscillator_puf #(.n2(3)) dut_tie (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .chall_in (chall_in),
        .response (response_t),
        .ready    (ready_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        en       = 1'b0;
        chall_in = 8'h00;
        edges(3);
        check("reset_response", response, 8'h00);
        check("reset_ready", {7'b0, ready}, 8'h00);

        rst = 1'b1;
        edges(1);
        en = 1'b1;
        edges(65);
        check("latency_not_yet", {7'b0, ready}, 8'h00);
        edges(1);
        check("latency_ready", {7'b0, ready}, 8'h01);
        check("chall_00", response, 8'h0A);
        check("tie_bit1", {7'b0, response_t[1]}, 8'h00);
        check("tie_chall_00", response_t, 8'h08);

        chall_in = 8'hFF;
        edges(3);
        check("hold_last_cycle", {7'b0, ready}, 8'h01);
        edges(1);
        check("hold_dropped", {7'b0, ready}, 8'h00);
        check("resp_held_idle", response, 8'h0A);
        edges(65);
        check("rearm_not_yet", {7'b0, ready}, 8'h00);
        edges(1);
        check("rearm_ready", {7'b0, ready}, 8'h01);
        check("chall_ff", response, 8'hFF & 8'h65);

        chall_in = 8'hD4;
        edges(70);
        check("ready_d4", {7'b0, ready}, 8'h01);
        check("chall_d4", response, 8'h4E);

        chall_in = 8'h00;
        edges(70);
        check("ready_00_again", {7'b0, ready}, 8'h01);
        check("chall_00_again", response, 8'h0A);

        edges(4);
        edges(20);
        en = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 80; i++) begin
            edges(1);
            if (ready) saw_ready = 1'b1;
        end
        check("en_low_no_ready", {7'b0, saw_ready}, 8'h00);
        check("en_low_resp_held", response, 8'h0A);

        chall_in = 8'hFF;
        en = 1'b1;
        edges(66);
        check("pre_reset_ready", {7'b0, ready}, 8'h01);
        check("pre_reset_resp", response, 8'h65);
        edges(1);
        rst = 1'b0;
        #1;
        check("async_reset_resp", response, 8'h00);
        check("async_reset_ready", {7'b0, ready}, 8'h00);
        #1;
        rst = 1'b1;
        edges(65);
        check("post_reset_not_yet", {7'b0, ready}, 8'h00);
        edges(1);
        check("post_reset_ready", {7'b0, ready}, 8'h01);
        check("post_reset_resp", response, 8'h65);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
